// File: rtl/vect_pkg.sv
// Shared definitions for the vector store unit: lane geometry, FSM encoding
// and the pixel clamp range used by the optional clamp build.
package vect_pkg;

  localparam int unsigned VEC_N   = 24;
  localparam int unsigned VEC_M   = 6;

  localparam int unsigned PIX_MIN = 0;
  localparam int unsigned PIX_MAX = 255;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } vstore_state_t;

endpackage

// File: rtl/vect_addr_gen.sv
// Lane address accumulator: loads the base address when a store starts and
// adds the stride each time a lane retires. Wraps modulo 2^ADDR_W.
module vect_addr_gen #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);

  // Address register: base on load, base + k*stride after k retirements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (advance) begin
      addr <= addr + stride;
    end
  end

endmodule

// File: rtl/vect_store_unit.sv
// Vector store unit: drains one packed M-lane result vector into a scalar
// data memory, one masked lane per step, with a valid/ready write handshake.
// Build option: define VSTORE_CLAMP_EN to clamp each signed lane to [0,255]
// before it drives mem_wdata.
module vect_store_unit
  import vect_pkg::*;
#(
  parameter int unsigned N      = VEC_N,
  parameter int unsigned M      = VEC_M,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [M*N-1:0]    vec_in,
  input  logic [M-1:0]      lane_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  input  logic              mem_ready
);

  localparam int unsigned LANE_W = (M > 1) ? $clog2(M) : 1;

  vstore_state_t     state;
  vstore_state_t     next_state;
  logic [LANE_W-1:0] lane;
  logic [M*N-1:0]    vec_q;
  logic [M-1:0]      mask_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [N-1:0]      lane_data;
  logic [N-1:0]      wdata_val;
  logic              lane_en;
  logic              accept;
  logic              retire;
  logic              last_lane;

  // Lane selection and retire condition for the current step.
  always_comb begin
    lane_data = vec_q[int'(lane) * int'(N) +: N];
    lane_en   = mask_q[lane];
    accept    = (state == IDLE) && start;
    retire    = (state == WRITE) && (!lane_en || mem_ready);
    last_lane = (lane == LANE_W'(M - 1));
  end

  // Write data formatting: raw lane or signed clamp to the pixel range.
  always_comb begin
`ifdef VSTORE_CLAMP_EN
    if (lane_data[N-1]) begin
      wdata_val = N'(PIX_MIN);
    end else if (lane_data > N'(PIX_MAX)) begin
      wdata_val = N'(PIX_MAX);
    end else begin
      wdata_val = lane_data;
    end
`else
    wdata_val = lane_data;
`endif
  end

  vect_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .advance (retire),
    .base    (base_addr),
    .stride  (stride_q),
    .addr    (cur_addr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = WRITE;
      WRITE:   if (retire && last_lane) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture of the store request and lane counter; inputs are sampled only
  // when a start is accepted, so later input changes cannot disturb a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= '0;
      mask_q   <= '0;
      stride_q <= '0;
      lane     <= '0;
    end else if (accept) begin
      vec_q    <= vec_in;
      mask_q   <= lane_mask;
      stride_q <= stride;
      lane     <= '0;
    end else if (retire && !last_lane) begin
      lane     <= lane + 1'b1;
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      WRITE: begin
        busy      = 1'b1;
        mem_we    = lane_en;
        mem_addr  = cur_addr;
        mem_wdata = wdata_val;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vect_store_unit.sv
// Directed testbench for vect_store_unit with hand-computed expectations.
module tb_vect_store_unit;

  localparam int unsigned N = 24;
  localparam int unsigned M = 6;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [M*N-1:0] vec_in;
  logic [M-1:0]  lane_mask;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic          busy;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] wr_cyc[$];
  logic [31:0] addr_at[64];
  logic [31:0] data_at[64];
  logic        we_at[64];
  int          done_cyc;

  vect_store_unit #(
    .N      (N),
    .M      (M),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_in    (vec_in),
    .lane_mask (lane_mask),
    .base_addr (base_addr),
    .stride    (stride),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [M*N-1:0] mkvec(input logic [N-1:0] first);
    logic [M*N-1:0] v;
    v = '0;
    for (int k = 0; k < int'(M); k++) v[k*N +: N] = first + N'(k);
    return v;
  endfunction

  // Issue one store and observe it cycle by cycle. Cycle 1 is the first
  // cycle after the edge that accepts start.
  task automatic run_store(input logic [M*N-1:0] v, input logic [M-1:0] m,
                           input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input int rlo, input int rhi, input int sa_cyc,
                           input int rst_cyc, input int budget);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc  = -1;
    mem_ready = 1'b1;
    start     = 1'b1;
    vec_in    = v;
    lane_mask = m;
    base_addr = b;
    stride    = s;
    @(posedge clk); #1;
    start     = 1'b0;
    vec_in    = ~v;
    lane_mask = ~m;
    base_addr = ~b;
    stride    = ~s;
    for (int c = 1; c <= budget; c++) begin
      mem_ready = !(c >= rlo && c <= rhi);
      if (c == sa_cyc) begin
        start  = 1'b1;
        vec_in = {M{24'h000055}};
      end else begin
        start = 1'b0;
      end
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", 32'(mem_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
      end
      #1;
      we_at[c]   = mem_we;
      addr_at[c] = 32'(mem_addr);
      data_at[c] = 32'(mem_wdata);
      if (mem_we && mem_ready) begin
        wr_addr.push_back(32'(mem_addr));
        wr_data.push_back(32'(mem_wdata));
        wr_cyc.push_back(32'(c));
      end
      if (done) begin
        done_cyc = c;
        check("done_busy", 32'(busy), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    if (done_cyc > 0) begin
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end
  endtask

  task automatic check_writes(input string tag, input int n, input int exp_done,
                              input logic [31:0] ea[6], input logic [31:0] ed[6],
                              input logic [31:0] ec[6]);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], ea[i]);
      check($sformatf("%s_data%0d", tag, i), wr_data[i], ed[i]);
      check($sformatf("%s_cyc%0d", tag, i), wr_cyc[i], ec[i]);
    end
  endtask

  initial begin
    logic [M*N-1:0] cv;
    rst_n     = 1'b0;
    start     = 1'b0;
    vec_in    = '0;
    lane_mask = '0;
    base_addr = '0;
    stride    = '0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full mask, unit stride
    run_store(mkvec(24'h1), 6'h3F, 16'h0100, 16'd1, 0, -1, 0, 0, 30);
    check_writes("full", 6, 7,
      '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105},
      '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6},
      '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6});

    // Alternate lanes, stride 4 (started on the cycle after idle returns)
    run_store(mkvec(24'h10), 6'b101010, 16'h0000, 16'd4, 0, -1, 0, 0, 30);
    check_writes("mask", 3, 7,
      '{32'd4, 32'd12, 32'd20, 32'd0, 32'd0, 32'd0},
      '{32'h11, 32'h13, 32'h15, 32'd0, 32'd0, 32'd0},
      '{32'd2, 32'd4, 32'd6, 32'd0, 32'd0, 32'd0});

    // Backpressure on lane 2 for three cycles
    run_store(mkvec(24'hA0), 6'h3F, 16'h0200, 16'd2, 3, 5, 0, 0, 30);
    check_writes("bp", 6, 10,
      '{32'h200, 32'h202, 32'h204, 32'h206, 32'h208, 32'h20A},
      '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5},
      '{32'd1, 32'd2, 32'd6, 32'd7, 32'd8, 32'd9});
    for (int c = 3; c <= 6; c++) begin
      check($sformatf("bp_hold_we%0d", c), 32'(we_at[c]), 32'd1);
      check($sformatf("bp_hold_addr%0d", c), addr_at[c], 32'h204);
      check($sformatf("bp_hold_data%0d", c), data_at[c], 32'hA2);
    end

    // Address wrap-around
    run_store(mkvec(24'h40), 6'h3F, 16'hFFFE, 16'd1, 0, -1, 0, 0, 30);
    check_writes("wrap", 6, 7,
      '{32'hFFFE, 32'hFFFF, 32'h0, 32'h1, 32'h2, 32'h3},
      '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45},
      '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6});

    // Start pulsed while busy is ignored
    run_store(mkvec(24'h30), 6'h3F, 16'h0300, 16'd1, 0, -1, 2, 0, 30);
    check_writes("restart", 6, 7,
      '{32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305},
      '{32'h30, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35},
      '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6});

    // Empty mask: no writes, same latency
    run_store(mkvec(24'h70), 6'h00, 16'h0400, 16'd1, 0, -1, 0, 0, 30);
    check_writes("empty", 0, 7,
      '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
      '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
      '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});

    // Reset asserted during lane 3: three writes, then nothing
    run_store(mkvec(24'h80), 6'h3F, 16'h0500, 16'd1, 0, -1, 0, 4, 15);
    check_writes("reset", 3, -1,
      '{32'h500, 32'h501, 32'h502, 32'd0, 32'd0, 32'd0},
      '{32'h80, 32'h81, 32'h82, 32'd0, 32'd0, 32'd0},
      '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0});
    check("reset_busy_after", 32'(busy), 32'd0);

    // Signed extremes: clamped in the clamp build, raw otherwise
    cv = '0;
    cv[0*N +: N] = 24'hFFFFFB;
    cv[1*N +: N] = 24'h000000;
    cv[2*N +: N] = 24'h000064;
    cv[3*N +: N] = 24'h0000FF;
    cv[4*N +: N] = 24'h000100;
    cv[5*N +: N] = 24'h7FFFFF;
    run_store(cv, 6'h3F, 16'h0000, 16'd1, 0, -1, 0, 0, 30);
`ifdef VSTORE_CLAMP_EN
    check_writes("clamp", 6, 7,
      '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5},
      '{32'd0, 32'd0, 32'd100, 32'd255, 32'd255, 32'd255},
      '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6});
`else
    check_writes("raw", 6, 7,
      '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5},
      '{32'hFFFFFB, 32'h0, 32'h64, 32'hFF, 32'h100, 32'h7FFFFF},
      '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
